// File: rtl/router_pkg.sv
// router_pkg: shared constants, FSM state encoding and small helpers for the
// 1x3 byte-stream packet router.
//   state_t           : FSM state codes 0..7 (DA, LFD, LD, FFS, LAF, LP, CPE, WTE)
//   FIFO_DEPTH        : entries per output FIFO
//   SOFT_RESET_CYCLES : stalled-consumer cycles before an output FIFO is flushed
//   ADDR_INVALID      : header address value that is never routed
package router_pkg;

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  localparam int         NUM_PORTS         = 3;
  localparam int         FIFO_DEPTH        = 16;
  localparam int         PTR_W             = 4;
  localparam int         CNT_W             = 5;
  localparam int         SOFT_RESET_CYCLES = 30;
  localparam int         WD_W              = 5;
  localparam logic [1:0] ADDR_INVALID      = 2'b11;

  // The host may only present a new byte while the FSM can take one.
  function automatic logic busy_of(input state_t s);
    return !((s == DA) || (s == LD));
  endfunction

  // Select one per-port status bit by a 2-bit address; address 3 reads as 0.
  function automatic logic pick(input logic [NUM_PORTS-1:0] v, input logic [1:0] a);
    case (a)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo: 16x8 synchronous FIFO with a registered read port.
//   clock, resetn : clock and asynchronous active-low reset
//   write, din    : push request and data (ignored while full)
//   read          : pop request (ignored while empty); dout updates on a pop
//   soft_reset    : synchronous flush of all entries; wins over write/read
//   full, empty   : occupancy flags derived from a 5-bit entry count
//   dout          : last popped byte, held between pops
module router_fifo
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       write,
  input  logic       read,
  input  logic       soft_reset,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] dout
);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  // Flags are from the start of the cycle, so a same-cycle pop never lets a
  // push into a full FIFO through.
  assign do_wr = write && !full;
  assign do_rd = read && !empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is readable.
  always_ff @(posedge clock) begin
    if (do_wr && !soft_reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/router_top.sv
// router_top: 1x3 packet router. A length-prefixed packet (header, payload,
// parity byte) arriving on data_in is steered to one of three output FIFOs
// selected by header bits [1:0]. A per-output watchdog flushes a FIFO whose
// consumer has stalled.
//   clock, resetn            : clock and asynchronous active-low reset
//   pkt_valid, data_in       : host byte stream (pkt_valid low on parity byte)
//   busy                     : host must hold its byte while high
//   err                      : parity mismatch on the most recent packet
//   read_enb_k               : pop request for output k
//   vld_out_k, data_out_k    : output k non-empty flag and last popped byte
module router_top
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       err,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2
);

  state_t                 state;
  logic [1:0]             addr;
  logic [7:0]             hold;
  logic                   hold_is_parity;
  logic [7:0]             parity;
  logic [7:0]             rx_parity;

  logic [NUM_PORTS-1:0]   full;
  logic [NUM_PORTS-1:0]   empty;
  logic [NUM_PORTS-1:0]   wr;
  logic [NUM_PORTS-1:0]   rd;
  logic [NUM_PORTS-1:0]   soft_rst;
  logic [7:0]             dout [NUM_PORTS];

  logic                   wr_any;
  logic [7:0]             wdata;
  logic                   dest_full;
  logic                   dest_empty;
  logic                   dest_flush;
  logic                   hdr_empty;

  assign rd         = {read_enb_2, read_enb_1, read_enb_0};
  assign dest_full  = pick(full, addr);
  assign dest_empty = pick(empty, addr);
  assign dest_flush = pick(soft_rst, addr);
  assign hdr_empty  = pick(empty, data_in[1:0]);

  assign busy       = busy_of(state);
  assign vld_out_0  = !empty[0];
  assign vld_out_1  = !empty[1];
  assign vld_out_2  = !empty[2];
  assign data_out_0 = dout[0];
  assign data_out_1 = dout[1];
  assign data_out_2 = dout[2];

  // Exactly one FIFO write source per state: the held header (LFD), the live
  // byte (LD, room available) or the byte parked while the FIFO was full (LAF).
  always_comb begin
    wr_any = 1'b0;
    wdata  = hold;
    case (state)
      LFD:     wr_any = 1'b1;
      LD: begin
        if (!dest_full) begin
          wr_any = 1'b1;
          wdata  = data_in;
        end
      end
      LAF:     wr_any = 1'b1;
      default: wr_any = 1'b0;
    endcase
  end

  assign wr = wr_any ? (3'b001 << addr) : 3'b000;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= DA;
      addr           <= '0;
      hold           <= '0;
      hold_is_parity <= 1'b0;
      parity         <= '0;
      rx_parity      <= '0;
      err            <= 1'b0;
    end else if ((state != DA) && dest_flush) begin
      // The destination was flushed by its watchdog: drop the packet.
      state <= DA;
    end else begin
      case (state)
        DA: begin
          if (pkt_valid && (data_in[1:0] != ADDR_INVALID)) begin
            addr   <= data_in[1:0];
            hold   <= data_in;
            parity <= '0;
            state  <= hdr_empty ? LFD : WTE;
          end
        end
        WTE: begin
          if (dest_empty) state <= LFD;
        end
        LFD: begin
          parity <= parity ^ hold;
          err    <= 1'b0;
          state  <= LD;
        end
        LD: begin
          if (dest_full) begin
            hold           <= data_in;
            hold_is_parity <= !pkt_valid;
            state          <= FFS;
          end else if (pkt_valid) begin
            parity <= parity ^ data_in;
          end else begin
            rx_parity <= data_in;
            state     <= LP;
          end
        end
        FFS: begin
          if (!dest_full) state <= LAF;
        end
        LAF: begin
          if (hold_is_parity) begin
            rx_parity <= hold;
            state     <= LP;
          end else begin
            parity <= parity ^ hold;
            state  <= LD;
          end
        end
        LP: begin
          err   <= (parity != rx_parity);
          state <= CPE;
        end
        CPE:     state <= DA;
        default: state <= DA;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    logic [WD_W-1:0] wd_cnt;
    logic            stall;

    assign stall       = !empty[k] && !rd[k];
    assign soft_rst[k] = stall && (wd_cnt == WD_W'(SOFT_RESET_CYCLES - 1));

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        wd_cnt <= '0;
      end else if (!stall || soft_rst[k]) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end

    router_fifo u_fifo (
      .clock      (clock),
      .resetn     (resetn),
      .write      (wr[k]),
      .read       (rd[k]),
      .soft_reset (soft_rst[k]),
      .din        (wdata),
      .full       (full[k]),
      .empty      (empty[k]),
      .dout       (dout[k])
    );
  end

endmodule

// File: tb/tb_router_top.sv
// tb_router_top: self-checking bench for router_top. A host task sends
// packets honouring busy, a per-port reader pops bytes and compares them with
// a per-port queue of the bytes each packet should deliver, and directed
// table entries plus hand-written sequences cover the multi-cycle corners.
module tb_router_top;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] rd_en;
  logic       busy;
  logic       err;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic [2:0] vld;

  router_top dut (
    .clock      (clock),
    .resetn     (resetn),
    .pkt_valid  (pkt_valid),
    .read_enb_0 (rd_en[0]),
    .read_enb_1 (rd_en[1]),
    .read_enb_2 (rd_en[2]),
    .data_in    (data_in),
    .busy       (busy),
    .err        (err),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2)
  );

  always #5 clock = ~clock;
  assign vld = {vld_out_2, vld_out_1, vld_out_0};

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q [3][$];
  int         rd_mode [3];
  logic       pend [3];
  int         rd_cnt [3];
  logic [7:0] first_byte [3];
  int         run1;
  int         last_run1;
  bit         abort_send;

  typedef struct {
    logic [1:0] addr;
    int         len;
    bit         bad;
    bit         exp_err;
    int         exp_n;
    logic [7:0] exp_first;
  } vec_t;

  function automatic logic [7:0] get_dout(input int k);
    case (k)
      0:       return data_out_0;
      1:       return data_out_1;
      default: return data_out_2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reader / scoreboard: one pop decision per port per cycle, result checked
  // at the following negedge against the expected byte order.
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (pend[k]) begin
        if (exp_q[k].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte port%0d actual=%0h required=none", k, get_dout(k));
        end else begin
          if (rd_cnt[k] == 0) first_byte[k] = get_dout(k);
          rd_cnt[k]++;
          check($sformatf("byte_port%0d", k), {24'd0, get_dout(k)}, {24'd0, exp_q[k].pop_front()});
        end
      end
      case (rd_mode[k])
        0:       rd_en[k] = 1'b0;
        1:       rd_en[k] = 1'b1;
        default: rd_en[k] = 1'($urandom_range(0, 1));
      endcase
      pend[k] = rd_en[k] && vld[k] && resetn;
    end
    if (vld[1] && !rd_en[1]) run1++;
    else begin
      if (run1 > 0) last_run1 = run1;
      run1 = 0;
    end
  end

  task automatic send_pkt(input logic [1:0] a, input int len, input bit bad);
    logic [7:0] b[$];
    logic [7:0] par;
    int         idx;
    int         budget;
    bit         taken;
    b.push_back({len[5:0], a});
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    par = 8'd0;
    foreach (b[i]) par ^= b[i];
    if (bad) par ^= 8'($urandom_range(1, 255));
    b.push_back(par);
    foreach (b[i]) exp_q[a].push_back(b[i]);
    idx    = 0;
    budget = 0;
    @(negedge clock);
    while ((idx < b.size()) && !abort_send && (budget < 2000)) begin
      pkt_valid = (idx < b.size() - 1);
      data_in   = b[idx];
      taken     = !busy;  // busy is stable until the next rising edge
      @(negedge clock);
      budget++;
      if (taken) idx++;
    end
    pkt_valid = 1'b0;
    data_in   = 8'd0;
    if (budget >= 2000) check("send_timeout", 32'(budget), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clock);
    while (busy && (n < 500)) begin
      @(negedge clock);
      n++;
    end
    check({name, "_idle"}, 32'(n < 500), 32'd1);
  endtask

  task automatic wait_drained(input int k);
    int n = 0;
    rd_mode[k] = 1;
    while (((exp_q[k].size() != 0) || vld[k] || pend[k]) && (n < 500)) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("drain_port%0d", k), 32'(n < 500), 32'd1);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      pend[k] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[5];
    int   n;
    bit   fell;
    tbl[0] = '{2'd0, 14, 1'b1, 1'b1, 16, 8'h38};
    tbl[1] = '{2'd1, 16, 1'b0, 1'b0, 18, 8'h41};
    tbl[2] = '{2'd2, 1,  1'b0, 1'b0, 3,  8'h06};
    tbl[3] = '{2'd0, 63, 1'b1, 1'b1, 65, 8'hFC};
    tbl[4] = '{2'd2, 5,  1'b0, 1'b0, 7,  8'h16};

    resetn     = 1'b0;
    pkt_valid  = 1'b0;
    data_in    = 8'd0;
    abort_send = 1'b0;
    run1       = 0;
    last_run1  = 0;
    for (int k = 0; k < 3; k++) begin
      rd_mode[k] = 0;
      pend[k]    = 1'b0;
      rd_cnt[k]  = 0;
      first_byte[k] = 8'd0;
    end
    rd_en = 3'b000;

    // Reset state
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_vld", {29'd0, vld}, 32'd0);
    check("rst_dout", {8'd0, data_out_2, data_out_1, data_out_0}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Directed packets with a continuously draining reader
    for (int k = 0; k < 3; k++) rd_mode[k] = 1;
    for (int i = 0; i < 5; i++) begin
      rd_cnt[tbl[i].addr] = 0;
      send_pkt(tbl[i].addr, tbl[i].len, tbl[i].bad);
      wait_idle($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
      wait_drained(tbl[i].addr);
      check($sformatf("tbl%0d_count", i), 32'(rd_cnt[tbl[i].addr]), 32'(tbl[i].exp_n));
      check($sformatf("tbl%0d_first", i), {24'd0, first_byte[tbl[i].addr]}, {24'd0, tbl[i].exp_first});
      check($sformatf("tbl%0d_err_hold", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
    end

    // Address 3 is never accepted
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      pkt_valid = 1'b1;
      data_in   = 8'h0F;
      check("addr3_busy", {31'd0, busy}, 32'd0);
    end
    @(negedge clock);
    pkt_valid = 1'b0;
    data_in   = 8'd0;
    repeat (2) @(negedge clock);
    check("addr3_vld", {29'd0, vld}, 32'd0);

    // FIFO 2 fills with no reader: FSM parks in FFS with busy held
    rd_mode[2] = 0;
    rd_cnt[2]  = 0;
    fork
      send_pkt(2'd2, 20, 1'b0);
      begin
        repeat (22) @(negedge clock);
        check("ffs_busy", {31'd0, busy}, 32'd1);
        check("ffs_vld2", {31'd0, vld_out_2}, 32'd1);
        repeat (2) @(negedge clock);
        check("ffs_busy_hold", {31'd0, busy}, 32'd1);
        rd_mode[2] = 1;
      end
    join
    wait_idle("ffs");
    check("ffs_err", {31'd0, err}, 32'd0);
    wait_drained(2);
    check("ffs_count", 32'(rd_cnt[2]), 32'd22);

    // Header for a non-empty FIFO waits in WTE until it drains
    rd_mode[0] = 0;
    rd_cnt[0]  = 0;
    send_pkt(2'd0, 3, 1'b0);
    wait_idle("wte_first");
    check("wte_vld0", {31'd0, vld_out_0}, 32'd1);
    fork
      send_pkt(2'd0, 2, 1'b0);
      begin
        repeat (4) @(negedge clock);
        check("wte_busy", {31'd0, busy}, 32'd1);
        check("wte_vld0_held", {31'd0, vld_out_0}, 32'd1);
        rd_mode[0] = 1;
      end
    join
    wait_idle("wte");
    wait_drained(0);
    check("wte_count", 32'(rd_cnt[0]), 32'd9);

    // Watchdog: FIFO 1 fills and is never read
    rd_mode[1] = 0;
    last_run1  = 0;
    fork
      send_pkt(2'd1, 20, 1'b0);
      begin
        repeat (22) @(negedge clock);
        abort_send = 1'b1;
      end
    join
    abort_send = 1'b0;
    n    = 0;
    fell = 1'b0;
    while (!fell && (n < 60)) begin
      @(negedge clock);
      n++;
      fell = !vld_out_1;
    end
    check("wd_vld1_fell", {31'd0, fell}, 32'd1);
    @(negedge clock);
    check("wd_run_len", 32'((last_run1 >= 29) && (last_run1 <= 31)), 32'd1);
    check("wd_busy", {31'd0, busy}, 32'd0);
    exp_q[1].delete();
    rd_mode[1] = 1;
    rd_cnt[1]  = 0;
    send_pkt(2'd1, 4, 1'b0);
    wait_idle("wd_next");
    wait_drained(1);
    check("wd_next_count", 32'(rd_cnt[1]), 32'd6);

    // Randomized traffic with random readers
    for (int k = 0; k < 3; k++) rd_mode[k] = 2;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] a;
      int         len;
      bit         bad;
      a   = 2'($urandom_range(0, 2));
      len = $urandom_range(1, 40);
      bad = 1'($urandom_range(0, 1));
      send_pkt(a, len, bad);
      wait_idle($sformatf("rnd%0d", i));
      check($sformatf("rnd%0d_err", i), {31'd0, err}, {31'd0, bad});
    end
    for (int k = 0; k < 3; k++) wait_drained(k);

    // Reset in the middle of a payload
    rd_mode[2] = 1;
    fork
      send_pkt(2'd2, 30, 1'b0);
      begin
        repeat (10) @(negedge clock);
        #2 resetn = 1'b0;
        clear_model();
        abort_send = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_vld", {29'd0, vld}, 32'd0);
        check("mid_rst_dout", {8'd0, data_out_2, data_out_1, data_out_0}, 32'd0);
      end
    join
    @(negedge clock);
    clear_model();
    resetn     = 1'b1;
    abort_send = 1'b0;
    @(negedge clock);
    check("post_rst_vld", {29'd0, vld}, 32'd0);
    rd_cnt[2] = 0;
    send_pkt(2'd2, 6, 1'b1);
    wait_idle("post_rst");
    check("post_rst_err", {31'd0, err}, 32'd1);
    wait_drained(2);
    check("post_rst_count", 32'(rd_cnt[2]), 32'd8);
    check("post_rst_first", {24'd0, first_byte[2]}, 32'h1A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_top.md
# router_top

Single-input, three-output (1x3) byte-stream packet router. One host port accepts length-prefixed packets with a trailing parity byte and steers each into one of three 16-deep output FIFOs. Each output has its own valid/read handshake. A per-output watchdog flushes a FIFO whose consumer stalls.

## Interface
- Parameters: none; fixed constants live in `router_pkg`.
- `clock` in 1: sole clock; all state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `pkt_valid` in 1: high for header and payload bytes; low for the parity byte.
- `read_enb_0`, `read_enb_1`, `read_enb_2` in 1 each: per-output pop request.
- `data_in` in 8: packet byte.
- `busy` out 1: host must hold `data_in` and `pkt_valid` while high.
- `err` out 1: parity mismatch on the last packet.
- `vld_out_0`, `vld_out_1`, `vld_out_2` out 1 each: output FIFO k is non-empty.
- `data_out_0`, `data_out_1`, `data_out_2` out 8 each: popped byte.

## Operation
- Packet format:
  - Header byte: bits [7:2] are the payload length L (1..63); bits [1:0] are the destination address (0..2).
  - Then L payload bytes.
  - Then one parity byte, presented with `pkt_valid`=0.
  - Expected parity = XOR of the header and all payload bytes.
- Address 3 is invalid: the header is ignored and the FSM stays in DA.
- FSM encoding is fixed, with `busy`=1 in every state except DA and LD:
  - 0 DA (decode address)
  - 1 LFD (load first data)
  - 2 LD (load data)
  - 3 FFS (FIFO full)
  - 4 LAF (load after full)
  - 5 LP (load parity)
  - 6 CPE (check parity error)
  - 7 WTE (wait till empty)
- FSM transitions:
  - DA: if `pkt_valid` and addr≠3, latch the address and the header into the hold register. Go to LFD if the destination FIFO is empty, else WTE.
  - WTE: go to LFD when the destination FIFO is empty.
  - LFD: write the held header; go to LD.
  - LD, destination FIFO full: capture `data_in` into the hold register; go to FFS.
  - LD, not full, `pkt_valid`=1: write `data_in`; stay in LD.
  - LD, not full, `pkt_valid`=0: write `data_in` (the parity byte); go to LP.
  - FFS: go to LAF when the FIFO is no longer full.
  - LAF: write the held byte. Go to LP if that byte was the parity byte, else LD.
  - LP: go to CPE.
  - CPE: go to DA.
- `err`:
  - Internal parity is reset at header acceptance and XORs every byte written with `pkt_valid`=1.
  - On the LP→CPE transition, `err` is registered as (internal parity ≠ received parity byte).
  - `err` holds until the next header is written in LFD, where it clears.
- Each input byte is written to the destination FIFO exactly once.
- Output side:
  - `vld_out_k` = !empty_k.
  - If `read_enb_k` and not empty, `data_out_k` is registered with the head byte, one byte per cycle.
  - Otherwise `data_out_k` holds its last value.
- Soft reset (watchdog):
  - A per-output counter increments while `vld_out_k`=1 and `read_enb_k`=0; it clears otherwise.
  - When the count reaches 30 cycles, FIFO k is flushed synchronously and the counter clears.
  - If the FSM is currently targeting k, it returns to DA and the packet is abandoned.

## Timing
- Reset values: FSM DA, all FIFOs empty, `busy`=0, `err`=0, `vld_out_*`=0, `data_out_*`=0, counters 0.
- Reset mid-packet: the packet is abandoned.
- Header accepted at edge t (DA→LFD). `busy` is high during t..t+1; the FIFO write occurs at edge t+1.
- `vld_out` rises after edge t+1.
- In LD, one byte is accepted per edge while `busy`=0.
- Read latency: `data_out_k` is valid one edge after `read_enb_k` is sampled high with the FIFO non-empty.
- FIFO full when it holds 16 entries:
  - A write into a full FIFO is never attempted; a same-cycle read does not unblock that cycle's write.
  - A read of an empty FIFO is ignored.
  - A simultaneous read and write on a non-empty, non-full FIFO changes the count by 0.
- Pointers are mod-16 with a 5-bit count; wrap-around is transparent.

## Structure
- `router_pkg`:
  - state enum with codes 0..7 as above
  - `FIFO_DEPTH`=16, `SOFT_RESET_CYCLES`=30, `ADDR_INVALID`=2'b11
- Sub-module `router_fifo`: 16x8 FIFO with write, read, soft_reset, full, empty and registered dout; instantiated three times.
- Top level holds the FSM, the address/hold/parity registers and the three watchdogs.

## Test plan
- Reset, then send a 14-byte packet to addr 0 with a wrong parity byte, reader draining continuously → 16 bytes (header 0x38 first) appear on `data_out_0`; `err`=1 after CPE.
- Send a 16-byte packet to addr 1 with correct parity → 18 bytes in order on `data_out_1`; `err` cleared and stays 0.
- Send a 20-byte packet to addr 2 with no reader until the FIFO fills → FFS; `busy` held while full; no byte lost or duplicated once reading starts.
- Send a header to addr 0 while FIFO 0 is non-empty → WTE with `busy`=1 until empty, then LFD.
- Fill FIFO 1 and never assert `read_enb_1` → after 30 cycles `vld_out_1` falls and the FSM returns to DA.
- Assert `resetn`=0 mid-payload → all outputs return to their reset values immediately; the next packet routes correctly.
